// File: rtl/bcd_value_pkg.sv
// Shared types and constants for the BCD-to-binary converter.
package bcd_value_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StShift  = 2'd1,
    StAdjust = 2'd2,
    StDone   = 2'd3
  } state_e;

  localparam int unsigned DefDigits    = 3;
  localparam int unsigned DefInWidth   = 4 * DefDigits;
  localparam int unsigned DigitLimit   = 9;
  localparam int unsigned AdjThreshold = 8;
  localparam int unsigned AdjAmount    = 3;

endpackage

// File: rtl/bcd_value_nibble_adjust.sv
// One BCD digit correction step: digits that reached 8+ after a right shift lose 3.
module bcd_nibble_adjust
  import bcd_value_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);

  always_comb begin
    if (nib_i >= 4'(AdjThreshold)) begin
      nib_o = nib_i - 4'(AdjAmount);
    end else begin
      nib_o = nib_i;
    end
  end

endmodule

// File: rtl/bcd_value.sv
// Sequential packed-BCD to binary converter (shift-right / subtract-3 double dabble).
module bcd_value
  import bcd_value_pkg::*;
#(
  parameter int unsigned DIGITS    = DefDigits,
  parameter int unsigned IN_WIDTH  = 4 * DIGITS,
  parameter int unsigned OUT_WIDTH = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IN_WIDTH-1:0]  bcd_in,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [OUT_WIDTH-1:0] value,
  output logic                 err,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int unsigned WorkW = 2 * IN_WIDTH;
  localparam int unsigned CntW  = $clog2(IN_WIDTH + 1);

  state_e               state_q, state_d;
  logic [WorkW-1:0]     work_q, work_d, work_shift, work_adj;
  logic [CntW-1:0]      cnt_q, cnt_d, cnt_inc;
  logic [OUT_WIDTH-1:0] value_q, value_d;
  logic                 err_q, err_d;
  logic                 out_valid_q, out_valid_d;
  logic [DIGITS-1:0]    digit_bad;
  logic [IN_WIDTH-1:0]  upper_adj;
  logic                 accept;

  for (genvar d = 0; d < DIGITS; d++) begin : g_digit
    bcd_nibble_adjust u_adj (
      .nib_i (work_q[IN_WIDTH + 4*d +: 4]),
      .nib_o (upper_adj[4*d +: 4])
    );
    assign digit_bad[d] = bcd_in[4*d +: 4] > 4'(DigitLimit);
  end

  assign work_shift = {1'b0, work_q[WorkW-1:1]};
  assign work_adj   = {upper_adj, work_q[IN_WIDTH-1:0]};
  assign cnt_inc    = cnt_q + 1'b1;

  // Gated by reset so no operand is offered while reset is held.
  assign in_ready = (state_q == StIdle) && reset;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    cnt_d       = cnt_q;
    value_d     = value_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          cnt_d = '0;
          if (|digit_bad) begin
            state_d     = StDone;
            value_d     = '0;
            err_d       = 1'b1;
            out_valid_d = 1'b1;
          end else begin
            state_d = StShift;
            work_d  = {bcd_in, {IN_WIDTH{1'b0}}};
          end
        end
      end
      StShift: begin
        work_d = work_shift;
        cnt_d  = cnt_inc;
        if (cnt_inc < CntW'(IN_WIDTH)) begin
          state_d = StAdjust;
        end else begin
          // Last shift needs no correction; the binary result is now the low half.
          state_d     = StDone;
          value_d     = work_shift[OUT_WIDTH-1:0];
          err_d       = 1'b0;
          out_valid_d = 1'b1;
        end
      end
      StAdjust: begin
        work_d  = work_adj;
        state_d = StShift;
      end
      StDone: begin
        if (out_ready) begin
          state_d     = StIdle;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      work_q      <= '0;
      cnt_q       <= '0;
      value_q     <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      cnt_q       <= cnt_d;
      value_q     <= value_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign value     = value_q;
  assign err       = err_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_bcd_value.sv
// Directed self-checking bench for bcd_value.
module tb_bcd_value;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] bcd_in;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  value;
  logic        err;
  logic        out_valid;
  logic        out_ready;

  int total = 0;
  int passed = 0;

  bcd_value dut (
    .clk       (clk),
    .reset     (reset),
    .bcd_in    (bcd_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .value     (value),
    .err       (err),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept one operand, scramble bcd_in, then wait for out_valid and check latency and result.
  task automatic convert(input logic [11:0] bcd, input logic [9:0] exp_v, input logic exp_e,
                         input int exp_lat, input string name);
    int n;
    total++;
    if (in_ready !== 1'b1) $display("FAIL %s in_ready before accept: got %b want 1", name, in_ready);
    else passed++;
    bcd_in   = bcd;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    bcd_in   = ~bcd;
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    total++;
    if (n !== exp_lat) $display("FAIL %s latency: got %0d want %0d", name, n, exp_lat);
    else passed++;
    total++;
    if (value !== exp_v) $display("FAIL %s value: got %0d want %0d", name, value, exp_v);
    else passed++;
    total++;
    if (err !== exp_e) $display("FAIL %s err: got %b want %b", name, err, exp_e);
    else passed++;
    if (out_ready === 1'b1) begin
      step();
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1)
        $display("FAIL %s handoff: got out_valid=%b in_ready=%b want 0/1", name, out_valid,
                 in_ready);
      else passed++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b1; bcd_in = 12'h123; out_ready = 1'b1;
    #3;
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || value !== 10'd0 || err !== 1'b0)
      $display("FAIL reset_state: got rdy=%b ov=%b v=%0d e=%b want 0/0/0/0", in_ready,
               out_valid, value, err);
    else passed++;
    step(); step();
    total++;
    if (out_valid !== 1'b0) $display("FAIL reset_hold out_valid: got %b want 0", out_valid);
    else passed++;
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) $display("FAIL reset_release in_ready: got %b want 1", in_ready);
    else passed++;
  endtask

  task automatic test_convert();
    out_ready = 1'b1;
    convert(12'h999, 10'd999, 1'b0, 23, "conv_999");
    convert(12'h250, 10'd250, 1'b0, 23, "conv_250");
    convert(12'h000, 10'd0, 1'b0, 23, "conv_000");
    convert(12'h901, 10'd901, 1'b0, 23, "conv_901");
    convert(12'h088, 10'd88, 1'b0, 23, "conv_088");
  endtask

  task automatic test_bad_digit();
    out_ready = 1'b1;
    convert(12'h1A5, 10'd0, 1'b1, 0, "bad_1A5");
    convert(12'hF00, 10'd0, 1'b1, 0, "bad_F00");
    convert(12'h017, 10'd17, 1'b0, 23, "after_bad_017");
  endtask

  task automatic test_back_pressure();
    int bad;
    out_ready = 1'b0;
    convert(12'h123, 10'd123, 1'b0, 23, "bp_123");
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      bcd_in   = 12'h456;
      in_valid = (i % 2) == 0;
      step();
      if (out_valid !== 1'b1 || value !== 10'd123 || err !== 1'b0 || in_ready !== 1'b0) bad++;
    end
    in_valid = 1'b0;
    total++;
    if (bad !== 0) $display("FAIL bp_hold: got %0d bad cycles want 0", bad);
    else passed++;
    out_ready = 1'b1;
    step();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || value !== 10'd123)
      $display("FAIL bp_release: got ov=%b rdy=%b v=%0d want 0/1/123", out_valid, in_ready,
               value);
    else passed++;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (out_valid !== 1'b0 || in_ready !== 1'b1) bad++;
    end
    total++;
    if (bad !== 0) $display("FAIL bp_no_queue: got %0d bad cycles want 0", bad);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int bad;
    out_ready = 1'b1;
    bcd_in   = 12'h777;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) step();
    reset = 1'b0;
    #1;
    total++;
    if (value !== 10'd0 || err !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0)
      $display("FAIL reset_mid: got v=%0d e=%b ov=%b rdy=%b want 0/0/0/0", value, err,
               out_valid, in_ready);
    else passed++;
    step(); step();
    reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (out_valid !== 1'b0) bad++;
    end
    total++;
    if (bad !== 0) $display("FAIL reset_stale: got %0d out_valid cycles want 0", bad);
    else passed++;
    convert(12'h042, 10'd42, 1'b0, 23, "post_reset_042");
  endtask

  initial begin
    test_reset();
    test_convert();
    test_bad_digit();
    test_back_pressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
